// File: rtl/i2d_core_pkg.sv
// i2d_core_pkg: shared widths, reset PC and fetch queue entry type for the i2d core.
package i2d_core_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/wishbone.sv
// wishbone: pipelined Wishbone read bundle with master/slave views.
interface wishbone #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic cyc, stb, we, stall, ack;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_r;
    modport pl_master(output cyc, stb, we, adr, input stall, ack, dat_r);
    modport pl_slave(input cyc, stb, we, adr, output stall, ack, dat_r);
endinterface

// File: rtl/core_if_fifo.sv
// core_if_fifo: synchronous instruction queue with a registered head that holds its last value when empty.
module core_if_fifo
    import i2d_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type T = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       din,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic do_push, do_pop;
    assign full = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop & !empty;
    assign do_push = push & (!full | do_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            count <= '0;
            head <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            // head tracks mem[rptr]; an incoming word bypasses when it becomes the new head
            if (do_pop && count > (PW+1)'(1)) head <= mem[rptr + 1'b1];
            else if (do_push && (empty || do_pop)) head <= din;
        end
    end
endmodule

// File: rtl/core_if_pf.sv
// core_if_pf: prefetching instruction fetch unit, pipelined Wishbone master feeding a valid/ready decode queue.
module core_if_pf
    import i2d_core_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    input  logic          wb_stall_i,
    input  logic          wb_ack_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          if_halt,
    input  logic          set_pc,
    input  logic [AW-1:0] new_pc,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [AW-1:0] if_pc,
    output logic [DW-1:0] if_instr
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;
    logic [AW-1:0] fetch_pc, resp_pc;
    logic [CW-1:0] count, outstanding, discard;
    logic accept, ack_ok, push, pop, full, empty;
    entry_t head;
    wishbone #(.AW(AW), .DW(DW)) wb ();
    assign wb.stall = wb_stall_i;
    assign wb.ack = wb_ack_i;
    assign wb.dat_r = wb_dat_i;
    assign wb_cyc_o = wb.cyc;
    assign wb_stb_o = wb.stb;
    assign wb_we_o = wb.we;
    assign wb_adr_o = wb.adr;
    // queued plus in-flight words never exceed the queue size, so acks always have room
    assign wb.stb = !rst && !if_halt && !set_pc && ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
    assign wb.cyc = wb.stb | (outstanding != '0);
    assign wb.we = 1'b0;
    assign wb.adr = fetch_pc;
    assign accept = wb.stb & !wb.stall;
    assign ack_ok = wb.ack & (outstanding != '0);
    assign push = ack_ok & (discard == '0) & !set_pc & !full;
    assign pop = if_valid & if_ready & !set_pc;
    assign if_valid = !empty;
    assign if_pc = head.pc;
    assign if_instr = head.instr;
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            discard <= '0;
        end else if (set_pc) begin
            fetch_pc <= new_pc & ~AW'(3);
            resp_pc <= new_pc & ~AW'(3);
            outstanding <= outstanding - CW'(ack_ok);
            discard <= outstanding - CW'(ack_ok);
        end else begin
            if (accept) fetch_pc <= fetch_pc + AW'(4);
            outstanding <= outstanding + CW'(accept) - CW'(ack_ok);
            if (ack_ok && discard != '0) discard <= discard - CW'(1);
            if (push) resp_pc <= resp_pc + AW'(4);
        end
    end
    core_if_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(set_pc),
        .din('{pc: resp_pc, instr: wb_dat_i}),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
endmodule

// File: tb/tb_core_if_pf.sv
// tb_core_if_pf: directed scenarios with a latency-programmable slave model and a pop scoreboard.
module tb_core_if_pf;
    logic clk = 0, rst = 1;
    logic wb_cyc_o, wb_stb_o, wb_we_o, stall = 0, ack = 0;
    logic [31:0] wb_adr_o, dat = 0, new_pc = 0, if_pc, if_instr;
    logic if_halt = 0, set_pc = 0, if_valid, if_ready = 0;
    int tests = 0, fails = 0, npop = 0, nacc = 0, lat = 1, cyc = 0;
    typedef struct {logic [31:0] adr; int due;} pend_t;
    pend_t pend[$];
    logic [31:0] exp_adr[$], exp_pc[$];
    always #5 clk = ~clk;
    core_if_pf dut (
        .clk(clk), .rst(rst),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_stall_i(stall), .wb_ack_i(ack), .wb_dat_i(dat),
        .if_halt(if_halt), .set_pc(set_pc), .new_pc(new_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );
    function automatic logic [31:0] word(logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic seq(logic [31:0] base, int n, bit to_adr);
        for (int i = 0; i < n; i++) begin
            if (to_adr) exp_adr.push_back(base + 32'(4 * i));
            else exp_pc.push_back(base + 32'(4 * i));
        end
    endtask
    task automatic do_reset(int l);
        tick();
        rst = 1; set_pc = 0; if_halt = 0; if_ready = 0; stall = 0; new_pc = 0; lat = l;
        exp_adr.delete(); exp_pc.delete();
        tick();
        tick();
        npop = 0;
    endtask
    // slave: in-order acks lat cycles after accept; also scoreboards request addresses
    initial forever begin
        @(negedge clk);
        cyc++;
        ack = 0;
        if (rst) begin
            pend.delete();
            nacc = 0;
        end else begin
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                ack = 1;
                dat = word(pend[0].adr);
                void'(pend.pop_front());
            end
            if (wb_stb_o && !stall) begin
                nacc++;
                if (exp_adr.size() != 0) chk("req_adr", wb_adr_o, exp_adr.pop_front());
                pend.push_back('{wb_adr_o, cyc + lat});
            end
        end
    end
    // monitor: every accepted instruction must match the head of the expectation queue
    initial forever begin
        @(negedge clk);
        if (!rst && !set_pc && if_valid && if_ready) begin
            npop++;
            if (exp_pc.size() == 0) chk("pop_extra", if_pc, 32'hxxxx_xxxx);
            else begin
                chk("pop_pc", if_pc, exp_pc[0]);
                chk("pop_instr", if_instr, word(exp_pc.pop_front()));
            end
        end
    end
    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);
        // streaming
        do_reset(1);
        seq(0, 16, 1); seq(0, 16, 0);
        if_ready = 1; rst = 0;
        @(negedge clk); chk("t1_stb", wb_stb_o, 1); chk("t1_adr0", wb_adr_o, 0);
        @(negedge clk); chk("t1_valid_early", if_valid, 0); chk("t1_adr1", wb_adr_o, 4);
        @(negedge clk); chk("t1_valid", if_valid, 1); chk("t1_pc0", if_pc, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("t1_stream", if_valid, 1);
        end
        tick(); chk("t1_pops", npop, 6);
        // fill the queue with decode stalled
        do_reset(1);
        seq(0, 20, 1);
        rst = 0;
        repeat (8) tick();
        @(negedge clk);
        chk("t2_stb", wb_stb_o, 0); chk("t2_cyc", wb_cyc_o, 0);
        chk("t2_valid", if_valid, 1); chk("t2_pc", if_pc, 0);
        tick(); chk("t2_nacc", nacc, 4);
        seq(0, 16, 0); if_ready = 1;
        repeat (12) tick();
        chk("t2_pops", 32'(npop >= 8), 1);
        // redirect with two stale requests in flight
        do_reset(3);
        seq(0, 2, 1); seq(32'h100, 16, 1);
        if_ready = 1; rst = 0;
        tick(); tick();
        set_pc = 1; new_pc = 32'h103; exp_pc.delete(); seq(32'h100, 16, 0);
        @(negedge clk); chk("t3_stb_redirect", wb_stb_o, 0); chk("t3_cyc", wb_cyc_o, 1);
        tick(); set_pc = 0;
        @(negedge clk); chk("t3_stb", wb_stb_o, 1); chk("t3_adr", wb_adr_o, 32'h100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t3_stale_dropped", if_valid, 0);
        end
        repeat (10) tick();
        chk("t3_pops", 32'(npop >= 2), 1);
        // redirect coinciding with an ack
        do_reset(3);
        seq(0, 2, 1); seq(32'h200, 16, 1);
        if_ready = 1; rst = 0;
        tick(); tick(); if_halt = 1;
        tick(); set_pc = 1; new_pc = 32'h200; exp_pc.delete(); seq(32'h200, 16, 0);
        @(negedge clk); chk("t4_stb_redirect", wb_stb_o, 0);
        tick(); set_pc = 0;
        @(negedge clk); chk("t4_valid_a", if_valid, 0); chk("t4_cyc_a", wb_cyc_o, 1); chk("t4_stb_halt", wb_stb_o, 0);
        tick();
        @(negedge clk); chk("t4_valid_b", if_valid, 0); chk("t4_cyc_b", wb_cyc_o, 0);
        tick(); if_halt = 0;
        @(negedge clk); chk("t4_stb", wb_stb_o, 1); chk("t4_adr", wb_adr_o, 32'h200);
        repeat (8) tick();
        chk("t4_pops", 32'(npop >= 2), 1);
        // halt drains in-flight responses into the queue
        do_reset(3);
        seq(0, 16, 1);
        rst = 0;
        tick(); tick(); if_halt = 1;
        tick();
        @(negedge clk); chk("t5_cyc_a", wb_cyc_o, 1); chk("t5_stb_a", wb_stb_o, 0); chk("t5_valid_a", if_valid, 0);
        tick();
        @(negedge clk); chk("t5_cyc_b", wb_cyc_o, 1); chk("t5_valid_b", if_valid, 1); chk("t5_pc_b", if_pc, 0);
        tick();
        @(negedge clk); chk("t5_cyc_c", wb_cyc_o, 0); chk("t5_pc_c", if_pc, 0);
        tick(); seq(0, 16, 0); if_halt = 0; if_ready = 1;
        repeat (10) tick();
        chk("t5_pops", 32'(npop >= 4), 1);
        // stall holds the request
        do_reset(1);
        seq(0, 8, 1);
        stall = 1; rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("t6_stb", wb_stb_o, 1); chk("t6_adr_hold", wb_adr_o, 0);
        end
        tick(); chk("t6_nacc0", nacc, 0); stall = 0;
        @(negedge clk); chk("t6_adr_go", wb_adr_o, 0);
        tick(); chk("t6_nacc1", nacc, 1);
        @(negedge clk); chk("t6_adr_next", wb_adr_o, 4);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
